vga_scan_ctrl: RTL and testbench

VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

---
 rtl/vga_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_vga_scan_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_ctrl.sv
// VGA 640x480 scan timing with a pixel enable at clk/2 and a frame-synchronous zone selector.
// Decoded syncs/blank follow the registered counters with zero latency; no backpressure.
module vga_scan_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn,
    output logic       clockVGA,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       frame_start,
    output logic [1:0] zone
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {
        NONE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } pend_t;

    pend_t      pend;
    pend_t      pend_base;
    pend_t      pend_nxt;
    logic       pix_tick;
    logic       frame_wrap;
    logic [1:0] btn_s1;
    logic [1:0] btn_s2;
    logic [1:0] btn_d;
    logic [1:0] press;

    assign frame_wrap = pix_tick && (hcount == H_LAST) && (vcount == V_LAST);
    assign clockVGA   = pix_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_tick    <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            frame_start <= 1'b0;
        end else begin
            pix_tick    <= ~pix_tick;
            frame_start <= frame_wrap;
            if (pix_tick) begin
                if (hcount == H_LAST) begin
                    hcount <= '0;
                    vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
                end else begin
                    hcount <= hcount + 10'd1;
                end
            end
        end
    end

    assign vga_hs      = !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
    assign vga_vs      = !((vcount >= VS_FIRST) && (vcount <= VS_LAST));
    assign vga_blank_n = (hcount < H_VIS) && (vcount < V_VIS);

    // Buttons are asynchronous: two-flop synchronizer, then a delayed copy for rise detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            btn_d  <= '0;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
            btn_d  <= btn_s2;
        end
    end

    assign press = btn_s2 & ~btn_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= NONE;
            zone <= 2'd0;
        end else begin
            pend <= pend_nxt;
            if (frame_wrap) begin
                case (pend)
                    UP:      zone <= zone + 2'd1;
                    DOWN:    zone <= zone - 2'd1;
                    default: zone <= zone;
                endcase
            end
        end
    end

    // The wrap consumes the pending step first, so a press landing on the wrap counts for the next frame.
    always_comb begin
        pend_base = frame_wrap ? NONE : pend;
        pend_nxt  = pend_base;
        case (press)
            2'b01:   pend_nxt = (pend_base == DOWN) ? NONE : UP;
            2'b10:   pend_nxt = (pend_base == UP)   ? NONE : DOWN;
            default: pend_nxt = pend_base;
        endcase
    end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl using a reduced timing set so whole frames fit in a short run.
module tb_vga_scan_ctrl;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 16 pixels per line
    localparam int VT = VA + VF + VS + VB;   // 9 lines per frame
    localparam int FR = HT * VT;             // 144 pixels = 288 clk per frame
    localparam int LIM = 2 * FR + 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] btn = 2'b00;
    logic       clockVGA, vga_hs, vga_vs, vga_blank_n, frame_start;
    logic [9:0] hcount, vcount;
    logic [1:0] zone;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int zone_glitch = 0;
    logic [1:0] prev_zone = 2'd0;

    vga_scan_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn(btn),
        .clockVGA(clockVGA),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n),
        .hcount(hcount),
        .vcount(vcount),
        .frame_start(frame_start),
        .zone(zone)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out", name);
    endtask

    // Monitor: every frame_start presents the zone for the new frame.
    always @(negedge clk) begin
        if (!reset && frame_start && exp_q.size() > 0)
            check("zone_at_wrap", int'(zone), exp_q.pop_front());
        if (!reset && !frame_start && zone != prev_zone)
            zone_glitch++;
        prev_zone = zone;
    end

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            timeout("drain");
            exp_q.delete();
        end
    endtask

    task automatic press(input logic [1:0] m);
        @(posedge clk); #1 btn = m;
        repeat (4) @(posedge clk);
        #1 btn = 2'b00;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(int'(hcount) == h && int'(vcount) == v && clockVGA == 1'b0) && n < LIM);
        if (n >= LIM) timeout("wait_pos");
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hcount"}, int'(hcount), 0);
        check({tag, "_vcount"}, int'(vcount), 0);
        check({tag, "_clockVGA"}, int'(clockVGA), 0);
        check({tag, "_zone"}, int'(zone), 0);
        check({tag, "_frame_start"}, int'(frame_start), 0);
        check({tag, "_hs"}, int'(vga_hs), 1);
        check({tag, "_vs"}, int'(vga_vs), 1);
        check({tag, "_blank_n"}, int'(vga_blank_n), 1);
    endtask

    initial begin
        int hs_low, blank_low, wraps, prev_h, n;
        int fs_cnt, vs_low, blank_hi;

        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;

        // One line: first advance on edge 2, hcount walks 0..HT-1 once.
        hs_low = 0; blank_low = 0; wraps = 0; prev_h = 0;
        for (int k = 1; k <= 2 * HT; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("edge1_clockVGA", int'(clockVGA), 1);
                check("edge1_hcount", int'(hcount), 0);
            end
            if (k == 2) check("edge2_hcount", int'(hcount), 1);
            if (!vga_hs) hs_low++;
            if (!vga_blank_n) blank_low++;
            if (prev_h == HT - 1 && int'(hcount) == 0) wraps++;
            prev_h = int'(hcount);
        end
        check("line_hcount_end", int'(hcount), 0);
        check("line_vcount_end", int'(vcount), 1);
        check("line_wraps", wraps, 1);
        check("line_hs_low_clk", hs_low, 2 * HS);
        check("line_blank_low_clk", blank_low, 2 * (HT - HA));

        // One full frame starting right after a frame_start.
        n = 0;
        do begin @(negedge clk); n++; end while (!frame_start && n < LIM);
        if (!frame_start) timeout("first_frame_start");
        fs_cnt = 0; vs_low = 0; blank_hi = 0;
        for (int k = 1; k <= 2 * FR; k++) begin
            @(negedge clk);
            if (frame_start) begin
                fs_cnt++;
                check("frame_start_at_origin", int'(hcount) + int'(vcount), 0);
            end
            if (!vga_vs) vs_low++;
            if (vga_blank_n) blank_hi++;
        end
        check("frame_start_count", fs_cnt, 1);
        check("frame_vs_low_clk", vs_low, 2 * VS * HT);
        check("frame_blank_hi_clk", blank_hi, 2 * VA * HA);

        // Up steps, including wrap from 3 to 0.
        repeat (20) @(posedge clk);
        press(2'b01);
        check("zone_hold_midframe", int'(zone), 0);
        exp_q.push_back(1); drain();
        press(2'b01); exp_q.push_back(2); drain();
        press(2'b01); exp_q.push_back(3); drain();
        press(2'b01); exp_q.push_back(0); drain();

        // Down from 0, then cancelling up+down.
        press(2'b10); exp_q.push_back(3); drain();
        press(2'b01); press(2'b10); exp_q.push_back(3); drain();
        press(2'b10); press(2'b01); exp_q.push_back(3); drain();

        // Simultaneous press is ignored.
        press(2'b11); exp_q.push_back(3); drain();

        // Up press detected on the wrap edge itself: applies one frame later.
        exp_q.push_back(3);
        wait_pos(HT - 2, VT - 1);
        @(posedge clk); #1 btn = 2'b01;
        repeat (4) @(posedge clk);
        #1 btn = 2'b00;
        drain();
        exp_q.push_back(0); drain();

        // Reset mid-frame discards a pending up step.
        press(2'b01);
        wait_pos(5, 2);
        #2 reset = 1'b1;
        #1 check_reset_vals("midrst");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(0); drain();

        check("zone_changes_off_wrap", zone_glitch, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
